digit_scan_ctrl: RTL

DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

---
 rtl/scan_pkg.sv | 24 ++
 rtl/scan_tick_gen.sv | 37 +++
 rtl/digit_scan_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared constants and helpers for the multiplexed digit scanner.
package scan_pkg;

    localparam logic [1:0] RATE_x1 = 2'd0;
    localparam logic [1:0] RATE_x2 = 2'd1;
    localparam logic [1:0] RATE_x4 = 2'd2;
    localparam logic [1:0] RATE_x8 = 2'd3;

    localparam logic [3:0] BRIGHT_MAX = 4'd15;

    // Ceiling log2, never less than 1 so derived vectors stay legal.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Scan-rate prescaler: one-cycle tick every TICK_DIV enabled clocks, synchronous clear.
module scan_tick_gen
    import scan_pkg::*;
#(
    parameter int unsigned TICK_DIV = 15625
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Multiplexed display scanner: steps the active digit, PWM-dims it and blanks
// the anodes briefly after each digit change to suppress ghosting.
module digit_scan_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned NUM_DIG   = 8,
    parameter int unsigned TICK_DIV  = 15625,
    parameter int unsigned BLANK_CYC = 16,
    localparam int unsigned SW       = clog2(NUM_DIG)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sync_in,
    input  logic [1:0]         rate_sel,
    input  logic [3:0]         bright,
    output logic [SW-1:0]      sel,
    output logic [NUM_DIG-1:0] an_n,
    output logic               blank,
    output logic               digit_pls,
    output logic               frame_pls
);

    localparam int unsigned BW = clog2(BLANK_CYC + 1);
    localparam logic [BW-1:0] BLANK_END = BW'(BLANK_CYC);
    localparam logic [SW-1:0] SEL_LAST = SW'(NUM_DIG - 1);

    logic               sync_ff1_q, sync_ff2_q, sync_ff3_q, sync_rise;
    logic               tick, dwell_end, advance, lit;
    logic               loaded_q;
    logic [1:0]         rate_q, rate_d;
    logic [2:0]         dwell_q, dwell_d;
    logic [SW-1:0]      sel_q, sel_d;
    logic [3:0]         pwm_q, pwm_d;
    logic [BW-1:0]      blk_q, blk_d;
    logic [NUM_DIG-1:0] an_n_q, an_n_d;
    logic               blank_q, digit_pls_q, frame_pls_q;

    assign sync_rise = sync_ff2_q & ~sync_ff3_q;

    scan_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (sync_rise),
        .tick(tick)
    );

    always_comb begin
        rate_d  = rate_q;
        dwell_d = dwell_q;
        sel_d   = sel_q;
        blk_d   = blk_q;
        pwm_d   = en ? pwm_q + 4'd1 : pwm_q;

        dwell_end = ({1'b0, dwell_q} == ((4'd1 << rate_q) - 4'd1));
        advance   = tick && dwell_end && !sync_rise;

        // First clock after reset release picks up the requested rate.
        if (!loaded_q) begin
            rate_d = rate_sel;
        end

        if (sync_rise) begin
            dwell_d = '0;
            sel_d   = '0;
            rate_d  = rate_sel;
        end else if (tick) begin
            if (dwell_end) begin
                dwell_d = '0;
                sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + SW'(1);
                rate_d  = rate_sel;
            end else begin
                dwell_d = dwell_q + 3'd1;
            end
        end

        if (sync_rise || advance) begin
            blk_d = '0;
        end else if (en && (blk_q < BLANK_END)) begin
            blk_d = blk_q + BW'(1);
        end

        // Anodes are derived from next-state so they switch with sel, never a cycle late.
        lit    = (bright == BRIGHT_MAX) || (pwm_d < bright);
        an_n_d = '1;
        if (en && lit && (blk_d >= BLANK_END)) begin
            an_n_d = ~(NUM_DIG'(1) << sel_d);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_ff1_q  <= 1'b0;
            sync_ff2_q  <= 1'b0;
            sync_ff3_q  <= 1'b0;
            loaded_q    <= 1'b0;
            rate_q      <= '0;
            dwell_q     <= '0;
            sel_q       <= '0;
            pwm_q       <= '0;
            blk_q       <= '0;
            an_n_q      <= '1;
            blank_q     <= 1'b1;
            digit_pls_q <= 1'b0;
            frame_pls_q <= 1'b0;
        end else begin
            sync_ff1_q  <= sync_in;
            sync_ff2_q  <= sync_ff1_q;
            sync_ff3_q  <= sync_ff2_q;
            loaded_q    <= 1'b1;
            rate_q      <= rate_d;
            dwell_q     <= dwell_d;
            sel_q       <= sel_d;
            pwm_q       <= pwm_d;
            blk_q       <= blk_d;
            an_n_q      <= an_n_d;
            blank_q     <= &an_n_d;
            digit_pls_q <= advance;
            frame_pls_q <= advance && (sel_d == '0);
        end
    end

    assign sel       = sel_q;
    assign an_n      = an_n_q;
    assign blank     = blank_q;
    assign digit_pls = digit_pls_q;
    assign frame_pls = frame_pls_q;

endmodule
